fpu_sequencer: RTL

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

---
 rtl/fpu_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sequencer
// Description : Single-issue FPU launch/write-back sequencer (IDLE/EXEC/WB).
//               Divide support is enabled by defining FPU_SEQ_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [3:0] fpu_control,
    input  logic [4:0] issue_fd,
    input  logic       flush,
    output logic       stall,
    output logic       fpu_start,
    output logic [3:0] fpu_op,
    output logic       wb_valid,
    output logic [4:0] wb_fd,
    output logic       busy,
    output logic       illegal
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_WB   = 2'd2;

    logic [1:0] r_state;
    logic [4:0] r_count;
    logic       r_fpu_start;
    logic       r_illegal;
    logic [3:0] r_fpu_op;
    logic [4:0] r_wb_fd;

    logic       w_accept;
    logic       w_legal;
    logic [4:0] w_lat_m1;

    // Counter preload is latency minus one so the last EXEC cycle sees zero.
    always_comb begin
        w_legal  = 1'b0;
        w_lat_m1 = 5'd0;
        case (fpu_control)
            4'd0, 4'd1: begin
                w_legal  = 1'b1;
                w_lat_m1 = 5'd2;
            end
            4'd2: begin
                w_legal  = 1'b1;
                w_lat_m1 = 5'd3;
            end
`ifdef FPU_SEQ_DIV_EN
            4'd3: begin
                w_legal  = 1'b1;
                w_lat_m1 = 5'd15;
            end
`endif
            4'd4, 4'd5: begin
                w_legal  = 1'b1;
                w_lat_m1 = 5'd0;
            end
            default: begin
                w_legal  = 1'b0;
                w_lat_m1 = 5'd0;
            end
        endcase
    end

    assign stall    = issue_valid && (r_state == c_EXEC);
    assign w_accept = issue_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_count     <= 5'd0;
            r_fpu_start <= 1'b0;
            r_illegal   <= 1'b0;
            r_fpu_op    <= 4'd0;
            r_wb_fd     <= 5'd0;
        end else begin
            r_fpu_start <= 1'b0;
            r_illegal   <= 1'b0;
            if (flush) begin
                r_state <= c_IDLE;
                r_count <= 5'd0;
            end else if (w_accept && w_legal) begin
                r_state     <= c_EXEC;
                r_count     <= w_lat_m1;
                r_fpu_start <= 1'b1;
                r_fpu_op    <= fpu_control;
                r_wb_fd     <= issue_fd;
            end else if (w_accept) begin
                // Illegal op: report it and drop back to IDLE (also from WB).
                r_state   <= c_IDLE;
                r_illegal <= 1'b1;
            end else begin
                case (r_state)
                    c_EXEC: begin
                        if (r_count == 5'd0) begin
                            r_state <= c_WB;
                        end else begin
                            r_count <= r_count - 5'd1;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign fpu_start = r_fpu_start;
    assign fpu_op    = r_fpu_op;
    assign wb_valid  = (r_state == c_WB);
    assign wb_fd     = r_wb_fd;
    assign busy      = (r_state != c_IDLE);
    assign illegal   = r_illegal;

endmodule
`default_nettype wire
